// File: rtl/mlp_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// mlp_layer_sequencer_if
//   Control bundle between the MLP layer sequencer and the shared neuron
//   datapath / top-level control.
//
//   init    : start request (to sequencer)
//   hold    : datapath stall (to sequencer)
//   busy    : sequencer is running
//   done    : one-cycle completion pulse
//   layer   : current weight layer index
//   neuron  : current neuron index
//   tap     : current input index within the neuron
//   acc_clr : load bias into accumulator
//   acc_en  : multiply-accumulate one tap
//   act_wr  : write activated result to the ping-pong buffer
//   in_sel  : 1 = MAC operand from external input, 0 = from buffer
//   wr_buf  : ping-pong buffer written by act_wr
//   out_buf : buffer that holds the final layer outputs
//
//   master : the sequencer side
//   slave  : the control/datapath side
// ---------------------------------------------------------------------------
interface mlp_layer_sequencer_if #(
    parameter int M = 3,
    parameter int N = 3
);
    localparam int LW = ($clog2(M - 1) < 1) ? 1 : $clog2(M - 1);
    localparam int NW = ($clog2(N) < 1) ? 1 : $clog2(N);

    logic          init;
    logic          hold;
    logic          busy;
    logic          done;
    logic [LW-1:0] layer;
    logic [NW-1:0] neuron;
    logic [NW-1:0] tap;
    logic          acc_clr;
    logic          acc_en;
    logic          act_wr;
    logic          in_sel;
    logic          wr_buf;
    logic          out_buf;

    modport master (
        input  init, hold,
        output busy, done, layer, neuron, tap,
        output acc_clr, acc_en, act_wr, in_sel, wr_buf, out_buf
    );

    modport slave (
        output init, hold,
        input  busy, done, layer, neuron, tap,
        input  acc_clr, acc_en, act_wr, in_sel, wr_buf, out_buf
    );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// ---------------------------------------------------------------------------
// mlp_layer_sequencer
//   Walks one shared neuron datapath over every neuron of every weight
//   layer: per neuron one bias-load cycle, N multiply-accumulate cycles and
//   one write cycle, layer-major then neuron then tap. Holds no data.
//
//   clk  : clock, all state on the rising edge
//   nrst : synchronous active-low reset
//   bus  : control bundle (master side), see mlp_layer_sequencer_if
// ---------------------------------------------------------------------------
module mlp_layer_sequencer #(
    parameter int M = 3,
    parameter int N = 3
) (
    input  logic                   clk,
    input  logic                   nrst,
    mlp_layer_sequencer_if.master  bus
);
    localparam int LW = ($clog2(M - 1) < 1) ? 1 : $clog2(M - 1);
    localparam int NW = ($clog2(N) < 1) ? 1 : $clog2(N);

    localparam logic [LW-1:0] LAYER_LAST = LW'(M - 2);
    localparam logic [NW-1:0] IDX_LAST   = NW'(N - 1);
    // Final layer M-2 writes buffer (M-2) mod 2.
    localparam logic          OUT_BUF    = 1'((M - 2) % 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_e;

    state_e        state_q,  state_d;
    logic [LW-1:0] layer_q,  layer_d;
    logic [NW-1:0] neuron_q, neuron_d;
    logic [NW-1:0] tap_q,    tap_d;
    logic          busy_q,   busy_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        layer_d  = layer_q;
        neuron_d = neuron_q;
        tap_d    = tap_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.init && !bus.hold) begin
                    state_d  = S_BIAS;
                    layer_d  = '0;
                    neuron_d = '0;
                    tap_d    = '0;
                end
            end
            S_BIAS: begin
                if (!bus.hold) begin
                    state_d = S_MAC;
                    tap_d   = '0;
                end
            end
            S_MAC: begin
                if (!bus.hold) begin
                    if (tap_q == IDX_LAST) begin
                        state_d = S_WRITE;
                    end else begin
                        tap_d = tap_q + NW'(1);
                    end
                end
            end
            S_WRITE: begin
                if (!bus.hold) begin
                    tap_d = '0;
                    if (neuron_q != IDX_LAST) begin
                        state_d  = S_BIAS;
                        neuron_d = neuron_q + NW'(1);
                    end else if (layer_q != LAYER_LAST) begin
                        state_d  = S_BIAS;
                        neuron_d = '0;
                        layer_d  = layer_q + LW'(1);
                    end else begin
                        // Last neuron of last layer: indices return to 0.
                        state_d  = S_DONE;
                        neuron_d = '0;
                        layer_d  = '0;
                    end
                end
            end
            // hold has no effect here; DONE always lasts exactly one cycle.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples its pre-edge inputs regardless of statement order.
        if (!nrst) begin
            state_q  <= S_IDLE;
            layer_q  <= '0;
            neuron_q <= '0;
            tap_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            neuron_q <= neuron_d;
            tap_q    <= tap_d;
            busy_q   <= busy_d;
        end
    end

    // Strobes are decoded from the current state and gated by hold so a
    // stalled cycle issues nothing to the datapath.
    assign bus.acc_clr = (state_q == S_BIAS)  && !bus.hold;
    assign bus.acc_en  = (state_q == S_MAC)   && !bus.hold;
    assign bus.act_wr  = (state_q == S_WRITE) && !bus.hold;
    assign bus.done    = (state_q == S_DONE);
    assign bus.busy    = busy_q;

    assign bus.layer   = layer_q;
    assign bus.neuron  = neuron_q;
    assign bus.tap     = tap_q;

    // Layer l writes buffer l mod 2 and reads the other one, so a buffer
    // is never read and written within the same layer.
    assign bus.in_sel  = (layer_q == '0);
    assign bus.wr_buf  = layer_q[0];
    assign bus.out_buf = OUT_BUF;
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mlp_layer_sequencer
//   Drives three sequencer instances (M,N) = (3,3), (2,1), (4,2) and
//   compares every observed cycle against an expected trace built from the
//   schedule rules (bias, N taps, write per neuron, then a done cycle).
// ---------------------------------------------------------------------------
module tb_mlp_layer_sequencer;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       acc_clr;
        logic       acc_en;
        logic       act_wr;
        logic       in_sel;
        logic       wr_buf;
        logic       out_buf;
        logic [3:0] layer;
        logic [3:0] neuron;
        logic [3:0] tap;
    } obs_t;

    typedef struct {
        obs_t o;
        bit   idx_care;   // indices/buffer selects checked on this cycle
        bit   stallable;  // hold freezes this step
    } op_t;

    typedef struct {
        bit   init;
        bit   hold;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic nrst;
    logic init_a, hold_a, init_b, hold_b, init_c, hold_c;
    obs_t obs_a, obs_b, obs_c;

    int   n_vec = 0;
    int   n_bad = 0;
    op_t  ops[$];

    always #5 clk = ~clk;

    mlp_layer_sequencer_if #(.M(3), .N(3)) if_a ();
    mlp_layer_sequencer_if #(.M(2), .N(1)) if_b ();
    mlp_layer_sequencer_if #(.M(4), .N(2)) if_c ();

    assign if_a.init = init_a;
    assign if_a.hold = hold_a;
    assign if_b.init = init_b;
    assign if_b.hold = hold_b;
    assign if_c.init = init_c;
    assign if_c.hold = hold_c;

    mlp_layer_sequencer #(.M(3), .N(3)) u_a (.clk(clk), .nrst(nrst), .bus(if_a));
    mlp_layer_sequencer #(.M(2), .N(1)) u_b (.clk(clk), .nrst(nrst), .bus(if_b));
    mlp_layer_sequencer #(.M(4), .N(2)) u_c (.clk(clk), .nrst(nrst), .bus(if_c));

    always_comb begin
        obs_a = '0;
        obs_a.busy = if_a.busy;     obs_a.done = if_a.done;
        obs_a.acc_clr = if_a.acc_clr; obs_a.acc_en = if_a.acc_en;
        obs_a.act_wr = if_a.act_wr; obs_a.in_sel = if_a.in_sel;
        obs_a.wr_buf = if_a.wr_buf; obs_a.out_buf = if_a.out_buf;
        obs_a.layer = 4'(if_a.layer); obs_a.neuron = 4'(if_a.neuron);
        obs_a.tap = 4'(if_a.tap);
    end

    always_comb begin
        obs_b = '0;
        obs_b.busy = if_b.busy;     obs_b.done = if_b.done;
        obs_b.acc_clr = if_b.acc_clr; obs_b.acc_en = if_b.acc_en;
        obs_b.act_wr = if_b.act_wr; obs_b.in_sel = if_b.in_sel;
        obs_b.wr_buf = if_b.wr_buf; obs_b.out_buf = if_b.out_buf;
        obs_b.layer = 4'(if_b.layer); obs_b.neuron = 4'(if_b.neuron);
        obs_b.tap = 4'(if_b.tap);
    end

    always_comb begin
        obs_c = '0;
        obs_c.busy = if_c.busy;     obs_c.done = if_c.done;
        obs_c.acc_clr = if_c.acc_clr; obs_c.acc_en = if_c.acc_en;
        obs_c.act_wr = if_c.act_wr; obs_c.in_sel = if_c.in_sel;
        obs_c.wr_buf = if_c.wr_buf; obs_c.out_buf = if_c.out_buf;
        obs_c.layer = 4'(if_c.layer); obs_c.neuron = 4'(if_c.neuron);
        obs_c.tap = 4'(if_c.tap);
    end

    function automatic int m_of(input int k);
        case (k)
            0:       return 3;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int n_of(input int k);
        case (k)
            0:       return 3;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic obs_t get_obs(input int k);
        case (k)
            0:       return obs_a;
            1:       return obs_b;
            default: return obs_c;
        endcase
    endfunction

    task automatic set_in(input int k, input bit i, input bit h);
        case (k)
            0:       begin init_a = i; hold_a = h; end
            1:       begin init_b = i; hold_b = h; end
            default: begin init_c = i; hold_c = h; end
        endcase
    endtask

    // Expected outputs while idle / after reset.
    function automatic obs_t idle_rec(input int m);
        obs_t r;
        r = '0;
        r.in_sel  = 1'b1;
        r.out_buf = 1'((m - 2) % 2);
        return r;
    endfunction

    // Schedule of a full run: one step per non-stalled cycle.
    function automatic void build_ops(input int m, input int n);
        obs_t r;
        ops.delete();
        for (int l = 0; l < m - 1; l++) begin
            for (int nn = 0; nn < n; nn++) begin
                r = idle_rec(m);
                r.busy   = 1'b1;
                r.layer  = 4'(l);
                r.neuron = 4'(nn);
                r.in_sel = (l == 0);
                r.wr_buf = 1'(l % 2);
                r.tap = 4'd0;
                r.acc_clr = 1'b1;
                ops.push_back('{r, 1'b1, 1'b1});
                r.acc_clr = 1'b0;
                for (int t = 0; t < n; t++) begin
                    r.tap = 4'(t);
                    r.acc_en = 1'b1;
                    ops.push_back('{r, 1'b1, 1'b1});
                end
                r.acc_en = 1'b0;
                r.act_wr = 1'b1;
                ops.push_back('{r, 1'b1, 1'b1});
            end
        end
        r = idle_rec(m);
        r.busy = 1'b1;
        r.done = 1'b1;
        ops.push_back('{r, 1'b0, 1'b0});
    endfunction

    task automatic check_obs(input string name, input int cyc, input obs_t act,
                             input obs_t exp, input bit idx_care);
        obs_t a, e;
        a = act;
        e = exp;
        if (!idx_care) begin
            a.layer = '0; a.neuron = '0; a.tap = '0; a.in_sel = 1'b0; a.wr_buf = 1'b0;
            e.layer = '0; e.neuron = '0; e.tap = '0; e.in_sel = 1'b0; e.wr_buf = 1'b0;
        end
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, a, e);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One run on instance k. Cycle 0 asserts init (edge E0 ends it); cycle c
    // is the c-th cycle after E0. Returns the cycle in which done was seen.
    task automatic run_seq(input int k, input int hold_start, input int hold_len,
                           input bit rand_hold, input int reinit_at,
                           input int rst_at, input bit init_hold,
                           output int done_cyc);
        int   m, n, p, stalls, n_clr, n_en, n_wr, n_busy, idle_seen, runlen;
        bit   aborted, h, care, idle_exp, finished;
        obs_t e, a;
        m = m_of(k);
        n = n_of(k);
        build_ops(m, n);
        p = 0; stalls = 0; n_clr = 0; n_en = 0; n_wr = 0; n_busy = 0;
        idle_seen = 0; aborted = 1'b0; finished = 1'b0; done_cyc = -1;
        runlen = (m - 1) * n * (n + 2);

        set_in(k, 1'b1, 1'b0);
        @(negedge clk);
        check_obs("idle before start", 0, get_obs(k), idle_rec(m), 1'b1);
        @(posedge clk); #1;

        for (int c = 1; c <= 400; c++) begin
            h = rand_hold ? ($urandom_range(0, 3) == 0)
                          : (c >= hold_start && c < hold_start + hold_len);
            set_in(k, init_hold || (c == reinit_at), h);
            nrst = (c == rst_at) ? 1'b0 : 1'b1;
            idle_exp = aborted || (p >= ops.size());
            if (idle_exp) begin
                e = idle_rec(m);
                care = 1'b1;
            end else begin
                e = ops[p].o;
                care = ops[p].idx_care;
                if (h && ops[p].stallable) begin
                    e.acc_clr = 1'b0; e.acc_en = 1'b0; e.act_wr = 1'b0;
                    stalls++;
                end else begin
                    p++;
                end
            end
            @(negedge clk);
            a = get_obs(k);
            check_obs("trace", c, a, e, care);
            n_clr += int'(a.acc_clr);
            n_en  += int'(a.acc_en);
            n_wr  += int'(a.act_wr);
            n_busy += int'(a.busy);
            if (a.done === 1'b1) done_cyc = c;
            @(posedge clk); #1;
            if (c == rst_at) aborted = 1'b1;
            if (idle_exp) idle_seen++;
            if (idle_seen >= (aborted ? 3 : 1)) begin
                finished = 1'b1;
                break;
            end
        end
        nrst = 1'b1;
        set_in(k, init_hold, 1'b0);

        check_int("run finished within budget", int'(finished), 1);
        if (aborted) begin
            check_int("no done after reset", done_cyc, -1);
        end else begin
            check_int("acc_clr count", n_clr, (m - 1) * n);
            check_int("acc_en count", n_en, (m - 1) * n * n);
            check_int("act_wr count", n_wr, (m - 1) * n);
            check_int("busy cycles", n_busy, runlen + 1 + stalls);
            check_int("done cycle", done_cyc, runlen + 1 + stalls);
        end
    endtask

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t r;
        int   dc;
        bit   seen;

        // Table for the smallest configuration M=2, N=1.
        r = idle_rec(2);
        vecs[0] = '{1'b0, 1'b0, r};                 // idle
        vecs[1] = '{1'b1, 1'b1, r};                 // hold blocks start
        vecs[2] = '{1'b1, 1'b0, r};                 // E0
        r.busy = 1'b1;
        r.acc_clr = 1'b1;
        vecs[3] = '{1'b0, 1'b0, r};                 // BIAS
        r.acc_clr = 1'b0;
        vecs[4] = '{1'b0, 1'b1, r};                 // MAC held
        r.acc_en = 1'b1;
        vecs[5] = '{1'b0, 1'b0, r};                 // MAC
        r.acc_en = 1'b0;
        r.act_wr = 1'b1;
        vecs[6] = '{1'b0, 1'b0, r};                 // WRITE
        r.act_wr = 1'b0;
        r.done = 1'b1;
        vecs[7] = '{1'b1, 1'b1, r};                 // DONE, hold/init ignored
        vecs[8] = '{1'b0, 1'b0, idle_rec(2)};       // back in IDLE

        nrst = 1'b0;
        for (int k = 0; k < 3; k++) set_in(k, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) set_in(k, 1'b0, 1'b0);
        nrst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_obs("reset state", 0, get_obs(k), idle_rec(m_of(k)), 1'b1);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            set_in(1, vecs[i].init, vecs[i].hold);
            @(negedge clk);
            check_obs("m2n1 vector", i, obs_b, vecs[i].exp, 1'b1);
            @(posedge clk); #1;
        end
        set_in(1, 1'b0, 1'b0);

        // Basic run, 30 active cycles then done in cycle 31.
        run_seq(0, 0, 0, 1'b0, 0, 0, 1'b0, dc);
        check_int("basic done at 31", dc, 31);
        // Hold 4 cycles at layer 1, neuron 2, tap 1 (cycle 28).
        run_seq(0, 28, 4, 1'b0, 0, 0, 1'b0, dc);
        check_int("hold run done at 35", dc, 35);
        // init re-asserted while busy.
        run_seq(0, 0, 0, 1'b0, 10, 0, 1'b0, dc);
        check_int("reinit run done at 31", dc, 31);
        // Reset mid-run, then a full fresh run.
        run_seq(0, 0, 0, 1'b0, 0, 15, 1'b0, dc);
        run_seq(0, 0, 0, 1'b0, 0, 0, 1'b0, dc);
        check_int("post-reset run done at 31", dc, 31);
        // Edge sizes.
        run_seq(2, 0, 0, 1'b0, 0, 0, 1'b0, dc);
        check_int("m4n2 done at 25", dc, 25);
        run_seq(1, 0, 0, 1'b0, 0, 0, 1'b0, dc);
        check_int("m2n1 done at 4", dc, 4);
        // Random stalls.
        for (int i = 0; i < 4; i++) run_seq(0, 0, 0, 1'b1, 0, 0, 1'b0, dc);
        for (int i = 0; i < 2; i++) run_seq(2, 0, 0, 1'b1, 0, 0, 1'b0, dc);

        // Back-to-back: init held through DONE; one idle cycle, then BIAS.
        run_seq(0, 0, 0, 1'b0, 0, 0, 1'b1, dc);
        set_in(0, 1'b0, 1'b0);
        build_ops(3, 3);
        @(negedge clk);
        check_obs("back-to-back restart", 1, obs_a, ops[0].o, 1'b1);
        @(posedge clk); #1;
        seen = 1'b0;
        for (int c = 2; c <= 60; c++) begin
            @(negedge clk);
            if (obs_a.done === 1'b1) begin
                seen = 1'b1;
                check_int("back-to-back done cycle", c, 31);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        check_int("back-to-back done seen", int'(seen), 1);
        @(negedge clk);
        check_obs("idle after back-to-back", 0, obs_a, idle_rec(3), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
